branch_sequencer: RTL and testbench

//  Sequences every control-transfer instruction for the single-cycle PC datapath.

---
 rtl/pc_ctrl_pkg.sv | 33 +++
 rtl/branch_decode.sv | 31 +++
 rtl/branch_sequencer.sv | 128 ++++++++++++
 tb/tb_branch_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and opcode constants for the branch sequencer and its decoder.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_TARGET = 2'd1,
        PC_REG    = 2'd2,
        PC_HOLD   = 2'd3
    } pc_sel_t;

    typedef enum logic [2:0] {
        BK_NONE = 3'd0,
        BK_B    = 3'd1,
        BK_BL   = 3'd2,
        BK_CBZ  = 3'd3,
        BK_BLT  = 3'd4,
        BK_BR   = 3'd5
    } br_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESOLVE = 2'd2
    } state_t;

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [4:0]  COND_LT  = 5'b01011;
    localparam logic [10:0] OP_BR    = 11'b11010110000;

endpackage

// File: rtl/branch_decode.sv
// Combinational classifier: instruction word -> branch kind and byte offset (sext(imm)<<2).
module branch_decode
    import pc_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output br_kind_t    kind,
    output logic [63:0] offset
);

    always_comb begin
        kind   = BK_NONE;
        offset = '0;
        if (instr[31:26] == OP_B) begin
            kind   = BK_B;
            offset = {{36{instr[25]}}, instr[25:0], 2'b00};
        end else if (instr[31:26] == OP_BL) begin
            kind   = BK_BL;
            offset = {{36{instr[25]}}, instr[25:0], 2'b00};
        end else if (instr[31:24] == OP_CBZ) begin
            kind   = BK_CBZ;
            offset = {{43{instr[23]}}, instr[23:5], 2'b00};
        end else if (instr[31:24] == OP_BCOND && instr[4:0] == COND_LT) begin
            // Only LT is supported; any other condition code is treated as a plain instruction.
            kind   = BK_BLT;
            offset = {{43{instr[23]}}, instr[23:5], 2'b00};
        end else if (instr[31:21] == OP_BR) begin
            kind   = BK_BR;
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Control-transfer sequencer: decodes branches, holds the PC while the condition
// settles, then steers the PC mux and counts taken branches.
module branch_sequencer
    import pc_ctrl_pkg::*;
#(
    parameter int RESOLVE_CYCLES = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    input  logic [63:0]      pc,
    input  logic [63:0]      reg_b,
    input  logic             zero_flag,
    input  logic             flag_n,
    input  logic             flag_v,
    output logic [1:0]       pc_sel,
    output logic [63:0]      pc_target,
    output logic             stall,
    output logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [2:0] WAIT_LOAD = 3'(RESOLVE_CYCLES - 1);

    br_kind_t    dec_kind;
    logic [63:0] dec_off;

    branch_decode u_decode (
        .instr  (instr),
        .kind   (dec_kind),
        .offset (dec_off)
    );

    state_t           state_q, state_d;
    br_kind_t         kind_q, kind_d;
    logic [63:0]      pc_target_q, pc_target_d;
    logic [2:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    pc_sel_t          sel;
    logic             taken;
    logic             stall_c;
    logic             flush_c;

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        pc_target_d = pc_target_q;
        wait_cnt_d  = wait_cnt_q;
        taken_cnt_d = taken_cnt_q;
        sel         = PC_HOLD;
        taken       = 1'b0;
        stall_c     = 1'b0;
        flush_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (dec_kind == BK_NONE) begin
                        sel = PC_SEQ;
                    end else begin
                        kind_d      = dec_kind;
                        pc_target_d = pc + dec_off;
                        wait_cnt_d  = WAIT_LOAD;
                        stall_c     = 1'b1;
                        state_d     = (RESOLVE_CYCLES == 1) ? ST_RESOLVE : ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall_c    = 1'b1;
                wait_cnt_d = wait_cnt_q - 3'd1;
                if (wait_cnt_d == 3'd0) state_d = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                case (kind_q)
                    BK_B, BK_BL, BK_BR: taken = 1'b1;
                    BK_CBZ:             taken = zero_flag;
                    BK_BLT:             taken = flag_n ^ flag_v;
                    default:            taken = 1'b0;
                endcase
                if (taken) sel = (kind_q == BK_BR) ? PC_REG : PC_TARGET;
                else       sel = PC_SEQ;
                flush_c = taken;
                if (taken && taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + CNT_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs read as idle while reset is held so an aborted branch never flushes.
        if (rst) begin
            sel     = PC_HOLD;
            stall_c = 1'b0;
            flush_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            kind_q      <= BK_NONE;
            pc_target_q <= '0;
            wait_cnt_q  <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            pc_target_q <= pc_target_d;
            wait_cnt_q  <= wait_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign pc_sel    = sel;
    assign pc_target = pc_target_q;
    assign stall     = stall_c;
    assign flush     = flush_c;
    assign busy      = !rst && (state_q != ST_IDLE);
    assign taken_cnt = taken_cnt_q;

    // Fetch must freeze the branch word and its address while we stall.
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        stall |=> ($stable(instr) && $stable(pc)));

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench: two sequencer instances (1-cycle / 3-cycle resolve) against a behavioural model.
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst [2];
    logic [31:0] instr [2];
    logic        iv [2];
    logic [63:0] pc [2];
    logic [63:0] reg_b [2];
    logic        zf [2];
    logic        fn [2];
    logic        fv [2];
    logic [1:0]  sel [2];
    logic [63:0] tgt [2];
    logic        stall [2];
    logic        flush [2];
    logic        busy [2];
    logic [3:0]  cnt0;
    logic [15:0] cnt1;

    int checks = 0;
    int failures = 0;
    longint exp_cnt [2];
    longint cnt_max [2];
    int     rcyc [2];

    always #5 clk = ~clk;

    branch_sequencer #(.RESOLVE_CYCLES(1), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst[0]), .instr(instr[0]), .instr_valid(iv[0]), .pc(pc[0]),
        .reg_b(reg_b[0]), .zero_flag(zf[0]), .flag_n(fn[0]), .flag_v(fv[0]),
        .pc_sel(sel[0]), .pc_target(tgt[0]), .stall(stall[0]), .flush(flush[0]),
        .busy(busy[0]), .taken_cnt(cnt0));

    branch_sequencer #(.RESOLVE_CYCLES(3), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst[1]), .instr(instr[1]), .instr_valid(iv[1]), .pc(pc[1]),
        .reg_b(reg_b[1]), .zero_flag(zf[1]), .flag_n(fn[1]), .flag_v(fv[1]),
        .pc_sel(sel[1]), .pc_target(tgt[1]), .stall(stall[1]), .flush(flush[1]),
        .busy(busy[1]), .taken_cnt(cnt1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cnt_of(input int d);
        return (d == 0) ? 64'(cnt0) : 64'(cnt1);
    endfunction

    // Model: 0 none, 1 B, 2 BL, 3 CBZ, 4 B.LT, 5 BR
    function automatic int kind_of(input logic [31:0] i);
        if (i[31:26] == 6'b000101) return 1;
        if (i[31:26] == 6'b100101) return 2;
        if (i[31:24] == 8'hB4) return 3;
        if (i[31:24] == 8'h54 && i[4:0] == 5'b01011) return 4;
        if (i[31:21] == 11'b11010110000) return 5;
        return 0;
    endfunction

    function automatic logic [63:0] target_of(input logic [31:0] i, input logic [63:0] p);
        longint off;
        case (kind_of(i))
            1, 2:    off = longint'($signed(i[25:0])) * 4;
            3, 4:    off = longint'($signed(i[23:5])) * 4;
            default: off = 0;
        endcase
        return p + 64'(off);
    endfunction

    function automatic logic [31:0] make_branch(input int k);
        case (k)
            1: return {6'b000101, 26'($urandom)};
            2: return {6'b100101, 26'($urandom)};
            3: return {8'hB4, 19'($urandom), 5'($urandom)};
            4: return {8'h54, 19'($urandom), 5'b01011};
            default: return {11'b11010110000, 5'b11111, 6'b0, 5'($urandom), 5'b0};
        endcase
    endfunction

    task automatic do_branch(input int d, input logic [31:0] ins, input logic [63:0] p,
                             input logic [63:0] rb, input logic z, input logic n, input logic v);
        int k;
        logic tk;
        logic [1:0] esel;
        k  = kind_of(ins);
        tk = (k == 1) || (k == 2) || (k == 5) || (k == 3 && z) || (k == 4 && (n ^ v));
        esel = !tk ? 2'd0 : (k == 5) ? 2'd2 : 2'd1;
        @(posedge clk); #1;
        instr[d] = ins; pc[d] = p; reg_b[d] = rb; zf[d] = z; fn[d] = n; fv[d] = v; iv[d] = 1'b1;
        for (int c = 0; c < rcyc[d]; c++) begin
            @(negedge clk);
            check($sformatf("d%0d stall c%0d", d, c), 64'(stall[d]), 64'(1));
            check($sformatf("d%0d hold c%0d", d, c), 64'(sel[d]), 64'(3));
            check($sformatf("d%0d busy c%0d", d, c), 64'(busy[d]), 64'(c > 0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check($sformatf("d%0d res_stall", d), 64'(stall[d]), 64'(0));
        check($sformatf("d%0d res_sel k%0d", d, k), 64'(sel[d]), 64'(esel));
        check($sformatf("d%0d res_flush", d), 64'(flush[d]), 64'(tk));
        if (k != 5) check($sformatf("d%0d target", d), tgt[d], target_of(ins, p));
        @(posedge clk); #1;
        iv[d] = 1'b0;
        if (tk && exp_cnt[d] < cnt_max[d]) exp_cnt[d]++;
        @(negedge clk);
        check($sformatf("d%0d taken_cnt", d), cnt_of(d), 64'(exp_cnt[d]));
        check($sformatf("d%0d idle_busy", d), 64'(busy[d]), 64'(0));
        check($sformatf("d%0d idle_flush", d), 64'(flush[d]), 64'(0));
    endtask

    task automatic do_plain(input int d, input logic [31:0] ins);
        @(posedge clk); #1;
        instr[d] = ins; iv[d] = 1'b1;
        @(negedge clk);
        check($sformatf("d%0d plain_sel", d), 64'(sel[d]), 64'(0));
        check($sformatf("d%0d plain_stall", d), 64'(stall[d]), 64'(0));
        @(posedge clk); #1;
        iv[d] = 1'b0;
        @(negedge clk);
        check($sformatf("d%0d novalid_sel", d), 64'(sel[d]), 64'(3));
    endtask

    initial begin
        rcyc[0] = 1; rcyc[1] = 3;
        cnt_max[0] = 15; cnt_max[1] = 65535;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; instr[d] = '0; iv[d] = 1'b0; pc[d] = '0; reg_b[d] = '0;
            zf[d] = 1'b0; fn[d] = 1'b0; fv[d] = 1'b0; exp_cnt[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_sel", 64'(sel[d]), 64'(3));
            check("rst_tgt", tgt[d], 64'(0));
            check("rst_cnt", cnt_of(d), 64'(0));
            check("rst_busy", 64'(busy[d]), 64'(0));
            check("rst_stall", 64'(stall[d]), 64'(0));
        end

        // Directed cases
        do_branch(0, {6'b000101, 26'd4}, 64'h100, 64'h0, 1'b0, 1'b0, 1'b0);
        check("t1_target", tgt[0], 64'h110);
        check("t1_cnt", cnt_of(0), 64'd1);
        do_branch(0, {8'hB4, 19'h7FFFE, 5'd3}, 64'h200, 64'h0, 1'b1, 1'b0, 1'b0);
        check("t2_target", tgt[0], 64'h1F8);
        do_branch(0, {8'hB4, 19'h7FFFE, 5'd3}, 64'h200, 64'h0, 1'b0, 1'b0, 1'b0);
        do_branch(0, {8'h54, 19'd3, 5'b01011}, 64'h40, 64'h0, 1'b0, 1'b1, 1'b0);
        check("t3_target", tgt[0], 64'h4C);
        do_branch(0, {8'h54, 19'd3, 5'b01011}, 64'h40, 64'h0, 1'b0, 1'b1, 1'b1);
        do_branch(1, {11'b11010110000, 5'b11111, 6'b0, 5'd7, 5'b0}, 64'h800, 64'hDEAD_0000,
                  1'b0, 1'b0, 1'b0);
        do_branch(1, {6'b000101, 26'd0}, 64'h3000, 64'h0, 1'b0, 1'b0, 1'b0);
        check("self_target", tgt[1], 64'h3000);
        do_plain(0, 32'h8B02_0020);
        do_plain(0, {8'h54, 19'd5, 5'b01100});

        // Reset mid-branch on the 3-cycle instance
        @(posedge clk); #1;
        instr[1] = {6'b000101, 26'd8}; pc[1] = 64'h500; iv[1] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_busy_wait", 64'(busy[1]), 64'(1));
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(negedge clk);
        check("t5_flush_rst", 64'(flush[1]), 64'(0));
        @(posedge clk); #1;
        rst[1] = 1'b0; iv[1] = 1'b0;
        exp_cnt[1] = 0;
        @(negedge clk);
        check("t5_busy", 64'(busy[1]), 64'(0));
        check("t5_flush", 64'(flush[1]), 64'(0));
        check("t5_stall", 64'(stall[1]), 64'(0));
        check("t5_cnt", cnt_of(1), 64'(0));
        check("t5_target", tgt[1], 64'(0));

        // Randomized branches and plain instructions on both instances
        for (int i = 0; i < 40; i++) begin
            int d;
            d = i % 2;
            if ($urandom_range(0, 4) == 0)
                do_plain(d, {6'b111111, 26'($urandom)});
            else
                do_branch(d, make_branch(int'($urandom_range(1, 5))), {$urandom, $urandom},
                          {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Saturation of the 4-bit counter
        for (int i = 0; i < 17; i++)
            do_branch(0, {6'b000101, 26'($urandom)}, {$urandom, $urandom}, 64'h0, 1'b0, 1'b0, 1'b0);
        check("t6_sat", cnt_of(0), 64'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
